// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
// Request and grant vectors are indexed with IDX_IF and IDX_DM.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int IDX_IF = 0;
  localparam int IDX_DM = 1;

  // Which requester the next-cycle read data belongs to
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_DM_RD = 2'd2
  } owner_e;

  // Port currently holding priority
  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_DM = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot, combinational grant.
// After any grant, priority passes to the port that was not granted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e prio_reg;
  port_e prio_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_reg <= SEL_DM;
    end else begin
      prio_reg <= prio_next;
    end
  end

  always_comb begin
    gnt       = 2'b00;
    prio_next = prio_reg;
    if (req[IDX_IF] && (!req[IDX_DM] || prio_reg == SEL_IF)) begin
      gnt[IDX_IF] = 1'b1;
      prio_next   = SEL_DM;
    end else if (req[IDX_DM]) begin
      gnt[IDX_DM] = 1'b1;
      prio_next   = SEL_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// load/store, routing the one-cycle-late read data back to its requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  owner_e     rsp_reg;
  owner_e     rsp_next;

  // Masking requests while reset is low keeps every strobe quiet during reset
  assign req = {dm_req & reset, if_req & reset};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign if_gnt = gnt[IDX_IF];
  assign dm_gnt = gnt[IDX_DM];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_next  = OWN_NONE;
    if (gnt[IDX_IF]) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      rsp_next = OWN_IF;
    end else if (gnt[IDX_DM]) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      rsp_next  = dm_we ? OWN_NONE : OWN_DM_RD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_reg <= OWN_NONE;
    end else begin
      rsp_reg <= rsp_next;
    end
  end

  assign if_rvalid = (rsp_reg == OWN_IF);
  assign dm_rvalid = (rsp_reg == OWN_DM_RD);
  assign if_rdata  = reset ? mem_rdata : '0;
  assign dm_rdata  = reset ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural model
// of the arbitration rules and a word-array image of memory.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      0:       return 32'h20080005;
      1:       return 32'h20090007;
      2:       return 32'h01095020;
      default: return (i * 32'h9E3779B1) ^ 32'h00001234;
    endcase
  endfunction

  // Synchronous single-port memory attached to the arbiter
  logic [DW-1:0] bmem [NW];
  logic          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NW; i++) bmem[i] <= init_word(i);
      loaded    <= 1'b1;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bmem[mem_addr];
    end
  end

  int reset_count = 0;
  always @(negedge reset) reset_count <= reset_count + 1;

  int tests = 0;
  int fails = 0;

  // Model state: who has priority, who owns next cycle's data, memory image
  bit            m_prio_dm;
  int            m_rsp;      // 0 none, 1 fetch, 2 load
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [NW];
  int            last_rc;
  bit            exp_gi, exp_gd, exp_wr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Compare the DUT against the model in mid-cycle, then advance the model
  task automatic step();
    bit gi, gd;
    @(negedge clk);
    if (reset_count != last_rc) begin
      m_prio_dm = 1'b1;
      m_rsp     = 0;
      last_rc   = reset_count;
    end
    if (!reset) begin
      chk("rst_if_gnt",    32'(if_gnt),    0);
      chk("rst_dm_gnt",    32'(dm_gnt),    0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
      chk("rst_mem_en",    32'(mem_en),    0);
      chk("rst_mem_we",    32'(mem_we),    0);
      chk("rst_mem_addr",  32'(mem_addr),  0);
      chk("rst_mem_wdata", mem_wdata,      0);
      chk("rst_if_rdata",  if_rdata,       0);
      chk("rst_dm_rdata",  dm_rdata,       0);
      m_prio_dm = 1'b1;
      m_rsp     = 0;
      exp_gi    = 1'b0;
      exp_gd    = 1'b0;
      exp_wr    = 1'b0;
      return;
    end
    gi = if_req && (!dm_req || !m_prio_dm);
    gd = dm_req && (!if_req || m_prio_dm);
    chk("if_gnt", 32'(if_gnt), 32'(gi));
    chk("dm_gnt", 32'(dm_gnt), 32'(gd));
    chk("mem_en", 32'(mem_en), 32'(gi || gd));
    chk("mem_we", 32'(mem_we), 32'(gd && dm_we));
    if (gi) chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
    if (gd) chk("mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
    if (gd && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(m_rsp == 1));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(m_rsp == 2));
    if (m_rsp == 1) chk("if_rdata", if_rdata, m_rdata);
    if (m_rsp == 2) chk("dm_rdata", dm_rdata, m_rdata);

    m_rsp = 0;
    if (gi) begin
      m_rsp     = 1;
      m_rdata   = m_mem[if_addr];
      m_prio_dm = 1'b1;
      $display("[TB] %0t IF  rd addr=%0d", $time, if_addr);
    end
    if (gd) begin
      m_prio_dm = 1'b0;
      if (dm_we) begin
        m_mem[dm_addr] = dm_wdata;
        $display("[TB] %0t DM  wr addr=%0d data=%08h", $time, dm_addr, dm_wdata);
      end else begin
        m_rsp   = 2;
        m_rdata = m_mem[dm_addr];
        $display("[TB] %0t DM  rd addr=%0d", $time, dm_addr);
      end
    end
    exp_gi = gi;
    exp_gd = gd;
    exp_wr = gd && dm_we;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] if_words [3];
  int          if_wait, dm_wait, dm_wait_max, if_got;

  initial begin
    if_words[0] = 32'h20080005;
    if_words[1] = 32'h20090007;
    if_words[2] = 32'h01095020;
    for (int i = 0; i < NW; i++) m_mem[i] = init_word(i);
    m_prio_dm = 1'b1;
    m_rsp     = 0;
    last_rc   = 0;
    exp_gi    = 1'b0;
    exp_gd    = 1'b0;
    exp_wr    = 1'b0;

    // Reset held with both ports requesting: nothing may be granted
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 12'd2048;
    step();
    chk("lit_reset_if_gnt", 32'(if_gnt), 0);
    chk("lit_reset_mem_en", 32'(mem_en), 0);
    adv(); step(); adv();

    // Fetch only, addresses 0,1,2
    reset = 1'b1; dm_req = 1'b0; if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr = AW'(k);
      step();
      chk("lit_ifonly_gnt", 32'(if_gnt), 1);
      if (k > 0) begin
        chk("lit_ifonly_rvalid", 32'(if_rvalid), 1);
        chk("lit_ifonly_rdata", if_rdata, if_words[k-1]);
      end
      adv();
    end
    if_req = 1'b0;
    step();
    chk("lit_ifonly_rvalid", 32'(if_rvalid), 1);
    chk("lit_ifonly_rdata", if_rdata, if_words[2]);
    adv();

    // Simultaneous requests right after a fresh reset
    reset = 1'b0;
    step(); adv();
    reset = 1'b1; if_req = 1'b1; if_addr = 12'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd2048;
    step();
    chk("lit_sim_first_dm", 32'(dm_gnt), 1);
    chk("lit_sim_first_if", 32'(if_gnt), 0);
    adv();
    dm_addr = 12'd2049;
    step();
    chk("lit_sim_second_if", 32'(if_gnt), 1);
    adv();
    for (int k = 0; k < 4; k++) begin
      if_addr = AW'(10 + k); dm_addr = AW'(2060 + k);
      step();
      chk("lit_alt_dm_gnt", 32'(dm_gnt), 32'(k % 2 == 0));
      chk("lit_alt_if_gnt", 32'(if_gnt), 32'(k % 2 == 1));
      adv();
    end

    // Data write then read-back of the same word
    if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'd2050; dm_wdata = 32'hDEADBEEF;
    step();
    chk("lit_wr_mem_we", 32'(mem_we), 1);
    adv();
    dm_we = 1'b0;
    step();
    chk("lit_wr_no_rvalid", 32'(dm_rvalid), 0);
    adv();
    dm_req = 1'b0;
    step();
    chk("lit_rd_rvalid", 32'(dm_rvalid), 1);
    chk("lit_rd_rdata", dm_rdata, 32'hDEADBEEF);
    adv();

    // Fairness: data port busy for 10 cycles, fetch joins in cycle 3
    if_wait = 0; dm_wait = 0; dm_wait_max = 0; if_got = -1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd2100;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin if_req = 1'b1; if_addr = 12'd7; end
      step();
      if (if_gnt && if_got < 0) if_got = c;
      if (dm_gnt) dm_wait = 0; else dm_wait++;
      if (dm_wait > dm_wait_max) dm_wait_max = dm_wait;
      adv();
      if (exp_gi) if_req = 1'b0;
      if (exp_gd) dm_addr = dm_addr + 1'b1;
    end
    chk("lit_fair_if_by_4", 32'(if_got >= 3 && if_got <= 4), 1);
    chk("lit_fair_dm_wait", 32'(dm_wait_max <= 1), 1);
    dm_req = 1'b0; if_req = 1'b0;
    step(); adv();

    // Reset asserted while a fetch read is in flight
    if_req = 1'b1; if_addr = 12'd3;
    step();
    chk("lit_midrd_gnt", 32'(if_gnt), 1);
    #2 reset = 1'b0;
    adv();
    if_req = 1'b0;
    step();
    chk("lit_midrd_no_rvalid", 32'(if_rvalid), 0);
    adv();
    reset = 1'b1; if_req = 1'b1; if_addr = 12'd4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd2070;
    step();
    chk("lit_release_dm_first", 32'(dm_gnt), 1);
    chk("lit_release_no_rvalid", 32'(if_rvalid), 0);
    adv();

    // Fetch lost to data above; withdraw it
    if_req = 1'b0; dm_req = 1'b0;
    step();
    chk("lit_withdraw_mem_en", 32'(mem_en), 0);
    adv();
    step();
    chk("lit_withdraw_no_rvalid", 32'(if_rvalid), 0);
    adv();

    // Random traffic honouring hold-until-grant, with occasional withdrawal and reset pulses
    for (int c = 0; c < 3000; c++) begin
      if (!reset && $urandom_range(0, 1) == 0) reset = 1'b1;
      if (!if_req || exp_gi) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 2047));
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req || exp_gd) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_addr  = AW'($urandom_range(0, NW - 1));
        dm_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req = 1'b0;
      end
      step();
      if (reset && !exp_wr && $urandom_range(0, 99) == 0) #2 reset = 1'b0;
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
